// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : N-bit add/subtract, split into STAGES equal carry-chain
//               chunks. The pipeline uses valid/ready handshakes and stalls
//               globally. Define PIPE_ADDER_OVF_EN to add the signed-overflow
//               output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int c_W = N / STAGES;

    logic              w_en;
    logic [N-1:0]      w_b_eff;

    // Per-stage sources: the module inputs for stage 0, otherwise the
    // previous stage register.
    logic [N-1:0]      w_src_a [STAGES];
    logic [N-1:0]      w_src_b [STAGES];
    logic [N-1:0]      w_src_s [STAGES];
    logic [STAGES-1:0] w_src_c;
    logic [STAGES-1:0] w_src_v;
    logic [c_W:0]      w_sum   [STAGES];

    logic [N-1:0]      r_a [STAGES];
    logic [N-1:0]      r_b [STAGES];
    logic [N-1:0]      r_s [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_v;

    // A full output slot that is not being taken freezes the whole pipe.
    assign w_en     = !r_v[STAGES-1] || out_ready;
    assign in_ready = w_en;
    assign w_b_eff  = sub ? ~b : b;

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        if (j == 0) begin : g_first
            assign w_src_a[j] = a;
            assign w_src_b[j] = w_b_eff;
            assign w_src_s[j] = '0;
            assign w_src_c[j] = c_in;
            assign w_src_v[j] = in_valid;
        end else begin : g_next
            assign w_src_a[j] = r_a[j-1];
            assign w_src_b[j] = r_b[j-1];
            assign w_src_s[j] = r_s[j-1];
            assign w_src_c[j] = r_c[j-1];
            assign w_src_v[j] = r_v[j-1];
        end

        assign w_sum[j] = {1'b0, w_src_a[j][j*c_W +: c_W]}
                        + {1'b0, w_src_b[j][j*c_W +: c_W]}
                        + {{c_W{1'b0}}, w_src_c[j]};

        // Operands ride along unchanged; only this stage's sum chunk is new.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v[j] <= 1'b0;
                r_c[j] <= 1'b0;
                r_a[j] <= '0;
                r_b[j] <= '0;
                r_s[j] <= '0;
            end else if (w_en) begin
                r_v[j] <= w_src_v[j];
                r_c[j] <= w_sum[j][c_W];
                r_a[j] <= w_src_a[j];
                r_b[j] <= w_src_b[j];
                r_s[j] <= w_src_s[j];
                r_s[j][j*c_W +: c_W] <= w_sum[j][c_W-1:0];
            end
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign s         = r_s[STAGES-1];
    assign c_out     = r_c[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    assign w_ovf = w_src_a[STAGES-1][N-1] ^ w_src_b[STAGES-1][N-1]
                 ^ w_sum[STAGES-1][c_W-1] ^ w_sum[STAGES-1][c_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Queue-scoreboard bench for pipelined_adder, covering
//               STAGES = 4, 1, 2 and 16 at N = 16 with shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    localparam int c_NI = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [15:0]     a;
    logic [15:0]     b;
    logic            c_in;
    logic            sub;
    logic            drain_chk;

    logic [c_NI-1:0] ir;
    logic [c_NI-1:0] ov;
    logic [c_NI-1:0] co;
    logic [15:0]     sv [c_NI];
`ifdef PIPE_ADDER_OVF_EN
    logic [c_NI-1:0] of;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, c_out, s} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yy;
        int unsigned t;
        logic [16:0] r;
        logic        v;
        yy = sb ? ~y : y;
        t  = 32'(x) + 32'(yy) + 32'(ci);
        r  = t[16:0];
        v  = (x[15] == yy[15]) && (r[15] != x[15]);
`ifndef PIPE_ADDER_OVF_EN
        v  = 1'b0;
`endif
        return {v, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] dut_out(input int k);
`ifdef PIPE_ADDER_OVF_EN
        return {of[k], co[k], sv[k]};
`else
        return {1'b0, co[k], sv[k]};
`endif
    endfunction

    for (genvar k = 0; k < c_NI; k++) begin : g_inst
        localparam int ST = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : 16;
        logic [17:0] q [$];
        logic [17:0] e;

        pipelined_adder #(.N(16), .STAGES(ST)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[k]),
            .a         (a),
            .b         (b),
            .c_in      (c_in),
            .sub       (sub),
            .out_valid (ov[k]),
            .out_ready (out_ready),
            .s         (sv[k]),
            .c_out     (co[k])
`ifdef PIPE_ADDER_OVF_EN
            ,
            .ovf       (of[k])
`endif
        );

        // Stimulus side: record every accepted operand set.
        always @(negedge clk) begin
            if (rst_n && in_valid && ir[k])
                q.push_back(model(a, b, c_in, sub));
        end

        // Monitor side: compare every delivered result in order.
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
            end else if (ov[k] && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_st%0d: got unexpected result %0h expected none", ST, dut_out(k));
                end else begin
                    e = q.pop_front();
                    chk($sformatf("sb_st%0d", ST), 32'(dut_out(k)), 32'(e));
                end
            end
            if (drain_chk)
                chk($sformatf("drain_st%0d", ST), q.size(), 0);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
        int t;
        a = x; b = y; c_in = ci; sub = sb; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!ir[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ir[0]) chk("send_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Single transaction into an idle pipe: checks latency and the sum.
    task automatic lat_chk(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic ci, input logic sb);
        logic [3:0]  seen;
        logic [17:0] got;
        seen = '0;
        got  = '0;
        a = x; b = y; c_in = ci; sub = sb; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            seen[i-1] = ov[0];
            if (i == 4) got = dut_out(0);
            if (i < 4) @(posedge clk);
        end
        chk({tag, "_lat"}, 32'(seen), 32'b1000);
        chk({tag, "_sum"}, 32'(got), 32'(model(x, y, ci, sb)));
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [17:0] exp0;
        logic [12:0] pat;
        logic [12:0] pat_exp;
        logic        any_ov;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; drain_chk = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_out_valid", 32'(ov), 0);
        chk("rst_sum", 32'(dut_out(0)), 0);
        chk("rst_in_ready", 32'(ir), 32'hF);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(ir), 32'hF);
        step();

        lat_chk("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle(4);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        idle(20);

        // Back-to-back burst of 8
        pat = '0; pat_exp = '0;
        for (int i = 0; i <= 12; i++) begin
            in_valid = (i < 8);
            a = 16'($urandom); b = 16'($urandom);
            c_in = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            pat[i]     = ov[0];
            pat_exp[i] = (i >= 4 && i <= 11);
            step();
        end
        chk("burst_pattern", 32'(pat), 32'(pat_exp));
        idle(20);

        // Full pipe held by out_ready = 0
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(16'(16'h1000 * i + 1), 16'(16'h0101 * i), 1'(i), 1'b0);
        exp0 = model(16'h0001, 16'h0000, 1'b0, 1'b0);
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b1; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(ir[0]), 0);
            chk("stall_valid", 32'(ov[0]), 1);
            chk("stall_hold", 32'(dut_out(0)), 32'(exp0));
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(ir[0]), 1);
        step();
        idle(20);

        // Reset with two transactions in flight
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h4321, 16'h0101, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        any_ov = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            any_ov = any_ov | ov[0];
            step();
        end
        chk("rst_flush", 32'(any_ov), 0);
        lat_chk("post_rst", 16'hBEEF, 16'h1001, 1'b1, 1'b1);
        idle(20);

        // Random traffic
        for (int cyc = 0; cyc < 10000; cyc++) begin
            a = 16'($urandom); b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'hFFFF;
            if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
            c_in      = 1'($urandom);
            sub       = 1'($urandom);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        out_ready = 1'b1;
        idle(40);

        drain_chk = 1'b1;
        step();
        drain_chk = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
